// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller: widths, IO window bit,
// access-size codes and the arbitrated request record.
package mem_ctrl_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int IO_HI_BIT  = 17;

    localparam logic [2:0] W_BYTE = 3'd1;
    localparam logic [2:0] W_HALF = 3'd2;
    localparam logic [2:0] W_WORD = 3'd4;

    typedef enum logic {OWN_IF = 1'b0, OWN_LSB = 1'b1} owner_e;

    typedef struct packed {
        owner_e                  owner;
        logic                    rw;
        logic [ADDR_WIDTH-1:0]   addr;
        logic [2:0]              width;
        logic [DATA_WIDTH-1:0]   data;
    } mem_req_t;

    // Unsupported size codes fall back to a full word.
    function automatic logic [2:0] norm_width(input logic [2:0] w);
        case (w)
            W_BYTE:  return W_BYTE;
            W_HALF:  return W_HALF;
            default: return W_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_req_arbiter.sv
// Combinational request select: the LSB port wins over instruction fetch.
module mem_req_arbiter
    import mem_ctrl_pkg::*;
(
    input  logic                  if_enable,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    input  logic                  lsb_enable,
    input  logic                  lsb_rw,
    input  logic [ADDR_WIDTH-1:0] lsb_addr,
    input  logic [DATA_WIDTH-1:0] lsb_data,
    input  logic [2:0]            lsb_width,
    output logic                  valid,
    output mem_req_t              req
);

    always_comb begin
        valid = if_enable | lsb_enable;
        req   = '0;
        if (lsb_enable) begin
            req.owner = OWN_LSB;
            req.rw    = lsb_rw;
            req.addr  = lsb_addr;
            req.width = norm_width(lsb_width);
            req.data  = lsb_data;
        end else begin
            req.owner = OWN_IF;
            req.rw    = 1'b0;
            req.addr  = if_addr;
            req.width = W_WORD;
            req.data  = '0;
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial controller between core request ports and the 8-bit RAM/IO port.
// Define MEM_CTRL_IO_STALL_EN to hold IO-region write bytes while io_buffer_full is set.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  io_buffer_full,
    input  logic                  if_enable,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_ok,
    output logic [DATA_WIDTH-1:0] if_data,
    input  logic                  lsb_enable,
    input  logic                  lsb_rw,
    input  logic [ADDR_WIDTH-1:0] lsb_addr,
    input  logic [DATA_WIDTH-1:0] lsb_data,
    input  logic [2:0]            lsb_width,
    output logic                  lsb_ok,
    output logic [DATA_WIDTH-1:0] lsb_rdata,
    input  logic                  mispredict
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_e;

    state_e                state_q, state_n;
    logic [2:0]            cnt_q, cnt_n, nxt;
    logic [2:0]            width_q, width_n;
    owner_e                owner_q, owner_n;
    logic [ADDR_WIDTH-1:0] addr_q, addr_n, mem_a_q, mem_a_n;
    logic [DATA_WIDTH-1:0] data_q, data_n, asm_data;
    logic [DATA_WIDTH-1:0] if_data_q, if_data_n, lsb_rdata_q, lsb_rdata_n;
    logic [7:0]            dout_q, dout_n;
    logic                  wr_q, wr_n, if_ok_q, if_ok_n, lsb_ok_q, lsb_ok_n;
    logic                  req_valid, io_stall;
    mem_req_t              req;

    mem_req_arbiter u_arb (
        .if_enable  (if_enable),
        .if_addr    (if_addr),
        .lsb_enable (lsb_enable),
        .lsb_rw     (lsb_rw),
        .lsb_addr   (lsb_addr),
        .lsb_data   (lsb_data),
        .lsb_width  (lsb_width),
        .valid      (req_valid),
        .req        (req)
    );

`ifdef MEM_CTRL_IO_STALL_EN
    assign io_stall = (state_q == S_WRITE) && (mem_a_q[IO_HI_BIT -: 2] == 2'b11) && io_buffer_full;
`else
    logic unused_io_full;
    assign unused_io_full = io_buffer_full;
    assign io_stall       = 1'b0;
`endif

    // Byte cnt-1 of the read arrives on mem_din during cycle cnt.
    always_comb begin
        asm_data = data_q;
        for (int i = 0; i < 4; i++)
            if (cnt_q == 3'(i + 1)) asm_data[8*i +: 8] = mem_din;
    end

    assign nxt = cnt_q + 3'd1;

    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        width_n     = width_q;
        owner_n     = owner_q;
        addr_n      = addr_q;
        data_n      = data_q;
        mem_a_n     = mem_a_q;
        dout_n      = dout_q;
        wr_n        = wr_q;
        if_ok_n     = 1'b0;
        lsb_ok_n    = 1'b0;
        if_data_n   = if_data_q;
        lsb_rdata_n = lsb_rdata_q;
        if (rdy) begin
            case (state_q)
                S_IDLE: if (req_valid && (req.rw || !mispredict)) begin
                    state_n = req.rw ? S_WRITE : S_READ;
                    cnt_n   = '0;
                    width_n = req.width;
                    owner_n = req.owner;
                    addr_n  = req.addr;
                    data_n  = req.rw ? req.data : '0;
                    mem_a_n = req.addr;
                    dout_n  = req.data[7:0];
                    wr_n    = req.rw;
                end
                S_READ: if (mispredict) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end else begin
                    if (cnt_q != 3'd0) data_n = asm_data;
                    if (cnt_q == width_q) begin
                        state_n = S_DONE;
                        cnt_n   = '0;
                        if (owner_q == OWN_LSB) begin
                            lsb_ok_n    = 1'b1;
                            lsb_rdata_n = asm_data;
                        end else begin
                            if_ok_n   = 1'b1;
                            if_data_n = asm_data;
                        end
                    end else begin
                        cnt_n = nxt;
                        if (nxt < width_q) mem_a_n = addr_q + ADDR_WIDTH'(nxt);
                    end
                end
                // Committed stores ignore mispredict and always run to completion.
                S_WRITE: if (!io_stall) begin
                    if (nxt < width_q) begin
                        cnt_n   = nxt;
                        mem_a_n = addr_q + ADDR_WIDTH'(nxt);
                        dout_n  = data_q[{nxt[1:0], 3'b000} +: 8];
                    end else begin
                        state_n  = S_DONE;
                        cnt_n    = '0;
                        wr_n     = 1'b0;
                        lsb_ok_n = 1'b1;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end else if (state_q == S_READ) begin
            // Bytes already in flight may be stale after a freeze; restart the read.
            cnt_n   = '0;
            mem_a_n = addr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            width_q     <= '0;
            owner_q     <= OWN_IF;
            addr_q      <= '0;
            data_q      <= '0;
            mem_a_q     <= '0;
            dout_q      <= '0;
            wr_q        <= 1'b0;
            if_ok_q     <= 1'b0;
            lsb_ok_q    <= 1'b0;
            if_data_q   <= '0;
            lsb_rdata_q <= '0;
        end else begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            width_q     <= width_n;
            owner_q     <= owner_n;
            addr_q      <= addr_n;
            data_q      <= data_n;
            mem_a_q     <= mem_a_n;
            dout_q      <= dout_n;
            wr_q        <= wr_n;
            if_ok_q     <= if_ok_n;
            lsb_ok_q    <= lsb_ok_n;
            if_data_q   <= if_data_n;
            lsb_rdata_q <= lsb_rdata_n;
        end
    end

    assign mem_a     = mem_a_q;
    assign mem_dout  = dout_q;
    assign mem_wr    = wr_q & rdy & ~io_stall;
    assign if_ok     = if_ok_q;
    assign if_data   = if_data_q;
    assign lsb_ok    = lsb_ok_q;
    assign lsb_rdata = lsb_rdata_q;

endmodule
